rally_referee: RTL and testbench
================================

// Module: rally_referee
// PURPOSE
// - Match-level referee directly downstream of the physics engine; consumes its per-frame
//   game_over/winner outputs and gates its 60 Hz enable.
// - Keeps both players' scores and freezes physics for a fixed pause after each point.
// - Declares the match winner at WIN_SCORE; a start button begins and restarts matches.
// - Scores and state drive the HUD/renderer.
// PARAMETERS
// WIN_SCORE     7    points needed to win the match (1..2^SCORE_W-1)
// PAUSE_FRAMES  90   frame_tick pulses physics stays frozen after a point (>=1)
// SCORE_W       4    width of each score counter
// PORTS
// clk           in   1        system clock
// rst_n         in   1        asynchronous active-low reset
// frame_tick    in   1        60 Hz one-clk pulse (frame enable source)
// start_btn     in   1        synchronous, debounced start level
// game_over     in   1        physics point-end flag (held >=1 frame, cleared by physics on next enable)
// winner        in   2        physics winner: 1=P1, 2=P2; 0/3 invalid
// phys_en       out  1        gated enable to physics = frame_tick && state==PLAY (combinational)
// p1_score      out  SCORE_W  P1 points
// p2_score      out  SCORE_W  P2 points
// point_pulse   out  1        one-clk pulse on every accepted point
// match_over    out  1        high in state DONE
// match_winner  out  2        1/2 once decided, 0 otherwise
// state         out  2        IDLE=0 PLAY=1 PAUSE=2 DONE=3
// BEHAVIOUR
// - Reset (async, any time, incl. mid-pause): state=IDLE; scores=0; point_pulse=0;
//   match_winner=0; pause counter=0; go_q=0; start_q=0. Outputs settle immediately.
// - go_q and start_q are one-clk delayed copies of game_over and start_btn, updated every clk.
//   go_rise = game_over & ~go_q. start_rise = start_btn & ~start_q.
// - State IDLE: phys_en=0. start_rise -> PLAY; scores and match_winner clear the same edge.
// - State PLAY: phys_en follows frame_tick.
//   - go_rise with winner==1 increments p1_score; winner==2 increments p2_score.
//   - On either increment: point_pulse=1 for that single clk.
//     - New score == WIN_SCORE -> DONE, match_winner=winner.
//     - Otherwise -> PAUSE, counter loaded with PAUSE_FRAMES.
//   - go_rise with winner 0 or 3: ignored; stay in PLAY; no pulse.
//   - A frame_tick coinciding with go_rise still produces phys_en that clk; the transition
//     takes effect next clk.
// - State PAUSE: phys_en=0, so physics holds game_over high and the ball parked.
//   - Each frame_tick decrements the counter; the tick that decrements it from 1 to 0 moves
//     to PLAY next clk. That tick itself is not forwarded.
//   - go_rise is ignored in PAUSE.
//   - The first forwarded tick in PLAY lets physics clear game_over and respawn the ball.
//     Because game_over stays high until then, no second point is counted.
// - State DONE: phys_en=0; scores and match_winner held.
//   - start_rise -> PLAY with scores=0 and match_winner=0.
// - start_btn in PLAY/PAUSE is ignored. A level held since reset or from a previous match
//   needs a fresh rise.
// - Scores increment by exactly 1 and saturate at 2^SCORE_W-1 (unreachable when WIN_SCORE is
//   legal). Pause counter width is $clog2(PAUSE_FRAMES+1).
// TESTING
// - Reset then release, no stimulus -> state=0, scores 0/0, phys_en=0 despite frame_tick.
// - start_btn rise -> state=1 next clk; each frame_tick appears on phys_en in the same clk.
// - game_over 0->1 with winner=1 -> p1_score=1, one point_pulse, state=2. phys_en stays 0
//   for 90 ticks and passes the 91st tick. Holding game_over=1 throughout adds no points.
// - Drive 7 P2 points with pauses -> after the 7th, state=3, match_over=1, match_winner=2,
//   p2_score=7. Later game_over rises change nothing. start_btn rise -> scores 0/0, state=1.
// - game_over rise with winner=0 in PLAY -> scores unchanged, no pulse, state stays 1.
// - Assert rst_n low mid-PAUSE (counter=40, score 3/2) -> immediately state=0, scores 0/0,
//   phys_en=0.

Source files
------------

// File: rtl/rally_referee.sv
// rally_referee -- match-level referee sitting after the physics engine.
//
// Watches the physics point-end flag (game_over/winner), keeps both scores,
// freezes physics for PAUSE_FRAMES frames after each point by withholding
// frame_tick, and declares the match winner at WIN_SCORE. A rising edge on
// start_btn begins a match from IDLE or restarts one from DONE.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   frame_tick      60 Hz one-clk frame pulse
//   start_btn       debounced start level (edge-detected here)
//   game_over       physics point-end flag, winner = 1 (P1) / 2 (P2)
//   phys_en         frame_tick forwarded to physics only while in PLAY
//   p1/p2_score     current scores
//   point_pulse     one-clk pulse per accepted point
//   match_over      high in DONE
//   match_winner    1/2 once the match is decided, else 0
//   state           IDLE=0 PLAY=1 PAUSE=2 DONE=3
module rally_referee #(
   parameter int WIN_SCORE    = 7,
   parameter int PAUSE_FRAMES = 90,
   parameter int SCORE_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               game_over,
   input  logic [1:0]         winner,
   output logic               phys_en,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               point_pulse,
   output logic               match_over,
   output logic [1:0]         match_winner,
   output logic [1:0]         state
);

   localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);
   localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

   state_t             st;
   logic [CNT_W-1:0]   cnt;
   logic               go_q, start_q;
   logic               go_rise, start_rise, valid_win;
   logic [SCORE_W-1:0] p1_nxt, p2_nxt;
   logic               won;

   assign go_rise    = game_over & ~go_q;
   assign start_rise = start_btn & ~start_q;
   assign valid_win  = (winner == 2'd1) || (winner == 2'd2);

   // saturating increments; the ceiling is unreachable for a legal WIN_SCORE
   assign p1_nxt = (&p1_score) ? p1_score : p1_score + 1'b1;
   assign p2_nxt = (&p2_score) ? p2_score : p2_score + 1'b1;
   assign won    = (winner == 2'd1) ? (p1_nxt == WIN_S) : (p2_nxt == WIN_S);

   assign phys_en    = frame_tick && (st == PLAY);
   assign match_over = (st == DONE);
   assign state      = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= IDLE;
         cnt          <= '0;
         go_q         <= 1'b0;
         start_q      <= 1'b0;
         p1_score     <= '0;
         p2_score     <= '0;
         point_pulse  <= 1'b0;
         match_winner <= 2'd0;
      end else begin
         go_q        <= game_over;
         start_q     <= start_btn;
         point_pulse <= 1'b0;
         case (st)
            IDLE, DONE: begin
               if (start_rise) begin
                  st           <= PLAY;
                  p1_score     <= '0;
                  p2_score     <= '0;
                  match_winner <= 2'd0;
               end
            end
            PLAY: begin
               // winner 0/3 is a malformed point end: dropped silently
               if (go_rise && valid_win) begin
                  point_pulse <= 1'b1;
                  if (winner == 2'd1) p1_score <= p1_nxt;
                  else                p2_score <= p2_nxt;
                  if (won) begin
                     st           <= DONE;
                     match_winner <= winner;
                  end else begin
                     st  <= PAUSE;
                     cnt <= PAUSE_LOAD;
                  end
               end
            end
            PAUSE: begin
               // game_over stays high here (physics is frozen), so go_rise
               // cannot occur until the first forwarded tick back in PLAY
               if (frame_tick) begin
                  if (cnt <= CNT_W'(1)) begin
                     cnt <= '0;
                     st  <= PLAY;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee. Each accepted point pushes its expected
// post-point scoreboard entry; a negedge monitor pops one entry per
// point_pulse and compares scores/state/winner. Other checks are inline.
module tb_rally_referee;

   localparam int PF = 90;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       game_over = 1'b0;
   logic [1:0] winner = 2'd0;
   logic       phys_en;
   logic [3:0] p1_score, p2_score;
   logic       point_pulse, match_over;
   logic [1:0] match_winner, state;

   int total = 0;
   int passed = 0;

   typedef struct {
      int p1;
      int p2;
      int st;
      int mw;
   } exp_t;
   exp_t sb[$];

   rally_referee #(.WIN_SCORE(7), .PAUSE_FRAMES(PF), .SCORE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
      .game_over(game_over), .winner(winner), .phys_en(phys_en),
      .p1_score(p1_score), .p2_score(p2_score), .point_pulse(point_pulse),
      .match_over(match_over), .match_winner(match_winner), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && point_pulse) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_pulse: got pulse expected none (p1=%0d p2=%0d st=%0d)",
                     p1_score, p2_score, state);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_p1", int'(p1_score), e.p1);
            chk("sb_p2", int'(p2_score), e.p2);
            chk("sb_state", int'(state), e.st);
            chk("sb_winner", int'(match_winner), e.mw);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic exp_en, input string nm);
      frame_tick = 1'b1;
      #1;
      chk(nm, int'(phys_en), int'(exp_en));
      cyc();
      frame_tick = 1'b0;
   endtask

   // a point whose rising game_over coincides with a frame tick
   task automatic score(input logic [1:0] w, input int ep1, input int ep2,
                        input int est, input int emw);
      exp_t e;
      e.p1 = ep1; e.p2 = ep2; e.st = est; e.mw = emw;
      sb.push_back(e);
      game_over  = 1'b1;
      winner     = w;
      frame_tick = 1'b1;
      #1;
      chk("tick_with_go", int'(phys_en), 1);
      cyc();
      frame_tick = 1'b0;
      cyc();
   endtask

   // PF gated ticks, then the first forwarded tick lets physics clear game_over
   task automatic pause_out(input int ticks);
      int seen = 0;
      for (int i = 0; i < ticks; i++) begin
         frame_tick = 1'b1;
         #1;
         seen += int'(phys_en);
         cyc();
         frame_tick = 1'b0;
         cyc();
      end
      chk("pause_gated", seen, 0);
      if (ticks == PF) begin
         chk("pause_end_state", int'(state), 1);
         tick(1'b1, "tick_after_pause");
         game_over = 1'b0;
         cyc();
      end
   endtask

   initial begin
      // reset, no stimulus
      cyc(); cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      chk("rst_state", int'(state), 0);
      chk("rst_p1", int'(p1_score), 0);
      chk("rst_p2", int'(p2_score), 0);
      chk("rst_mw", int'(match_winner), 0);
      chk("rst_pulse", int'(point_pulse), 0);
      tick(1'b0, "idle_gated");

      // start
      start_btn = 1'b1;
      cyc();
      chk("start_state", int'(state), 1);
      tick(1'b1, "play_tick_a");
      cyc();
      tick(1'b1, "play_tick_b");

      // P1 point with pause; game_over held high throughout
      score(2'd1, 1, 0, 2, 0);
      chk("p1_pause_state", int'(state), 2);
      pause_out(PF);
      chk("p1_held_score", int'(p1_score), 1);

      // malformed winners ignored
      game_over = 1'b1; winner = 2'd0; cyc(); cyc();
      chk("w0_state", int'(state), 1);
      chk("w0_p1", int'(p1_score), 1);
      chk("w0_p2", int'(p2_score), 0);
      game_over = 1'b0; cyc();
      game_over = 1'b1; winner = 2'd3; cyc(); cyc();
      chk("w3_state", int'(state), 1);
      game_over = 1'b0; cyc();

      // P2 wins 7 points
      for (int k = 1; k <= 7; k++) begin
         score(2'd2, 1, k, (k == 7) ? 3 : 2, (k == 7) ? 2 : 0);
         if (k < 7) pause_out(PF);
      end
      chk("done_state", int'(state), 3);
      chk("done_over", int'(match_over), 1);
      chk("done_winner", int'(match_winner), 2);
      chk("done_p2", int'(p2_score), 7);
      tick(1'b0, "done_gated");

      // later rises change nothing; held start level does not restart
      game_over = 1'b0; cyc();
      game_over = 1'b1; winner = 2'd1; cyc(); cyc();
      chk("done_p1_held", int'(p1_score), 1);
      chk("done_held_state", int'(state), 3);
      game_over = 1'b0;

      // fresh start rise restarts
      start_btn = 1'b0; cyc();
      start_btn = 1'b1; cyc();
      chk("restart_state", int'(state), 1);
      chk("restart_p1", int'(p1_score), 0);
      chk("restart_p2", int'(p2_score), 0);
      chk("restart_mw", int'(match_winner), 0);
      chk("restart_over", int'(match_over), 0);
      cyc();

      // reach 3/2, then reset mid-pause with counter at 40
      score(2'd1, 1, 0, 2, 0); pause_out(PF);
      score(2'd1, 2, 0, 2, 0); pause_out(PF);
      score(2'd1, 3, 0, 2, 0); pause_out(PF);
      score(2'd2, 3, 1, 2, 0); pause_out(PF);
      score(2'd2, 3, 2, 2, 0);
      pause_out(PF - 40);
      chk("pre_rst_state", int'(state), 2);
      chk("pre_rst_p1", int'(p1_score), 3);
      chk("pre_rst_p2", int'(p2_score), 2);
      frame_tick = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_p1", int'(p1_score), 0);
      chk("async_rst_p2", int'(p2_score), 0);
      chk("async_rst_phys", int'(phys_en), 0);
      frame_tick = 1'b0;
      cyc();

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
